// File: rtl/prim_fifo_sync_wm.sv
// Single-clock FIFO with phase-bit pointers (any Depth), optional same-cycle
// pass-through when empty, synchronous clear, occupancy output and sticky error.
// Optional watermark outputs are built when PRIM_FIFO_WATERMARK_EN is defined.
module prim_fifo_sync_wm #(
   parameter int unsigned Width  = 16,
   parameter int unsigned Depth  = 4,
   parameter bit          Pass   = 1'b1,
   parameter int unsigned DepthW = $clog2(Depth + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              wvalid_i,
   output logic              wready_o,
   input  logic [Width-1:0]  wdata_i,
   output logic              rvalid_o,
   input  logic              rready_i,
   output logic [Width-1:0]  rdata_o,
   output logic [DepthW-1:0] depth_o,
   output logic              err_o
`ifdef PRIM_FIFO_WATERMARK_EN
   ,
   input  logic [DepthW-1:0] wm_hi_i,
   input  logic [DepthW-1:0] wm_lo_i,
   output logic              afull_o,
   output logic              aempty_o
`endif
);

   localparam int unsigned PtrvW = (Depth > 1) ? $clog2(Depth) : 1;
   // Two spare bits so a corrupted pointer pair shows up as depth > Depth.
   localparam int unsigned CalcW = PtrvW + 2;
   localparam logic [PtrvW-1:0] MaxV   = PtrvW'(Depth - 1);
   localparam logic [CalcW-1:0] DepthC = CalcW'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrvW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic             err_q, err_d;
   logic             full, empty, pass_thru, wr_en, rd_en;
   logic [CalcW-1:0] depth_cur;

   // Pointer step: value wraps at Depth-1 and the phase bit toggles on wrap.
   function automatic logic [PtrvW:0] ptr_inc(input logic [PtrvW:0] p);
      logic [PtrvW:0] r;
      if (p[PtrvW-1:0] == MaxV) r = {~p[PtrvW], {PtrvW{1'b0}}};
      else                      r = {p[PtrvW], p[PtrvW-1:0] + 1'b1};
      return r;
   endfunction

   // Occupancy from a pointer pair.
   function automatic logic [CalcW-1:0] depth_f(input logic [PtrvW:0] wp,
                                                input logic [PtrvW:0] rp);
      logic [CalcW-1:0] wv, rv, r;
      wv = CalcW'(wp[PtrvW-1:0]);
      rv = CalcW'(rp[PtrvW-1:0]);
      if (wv == rv && wp[PtrvW] != rp[PtrvW]) r = DepthC;
      else if (wp[PtrvW] == rp[PtrvW])        r = wv - rv;
      else                                    r = DepthC - rv + wv;
      return r;
   endfunction

   assign full      = (wptr_q[PtrvW-1:0] == rptr_q[PtrvW-1:0]) && (wptr_q[PtrvW] != rptr_q[PtrvW]);
   assign empty     = (wptr_q == rptr_q);
   assign pass_thru = Pass && empty && wvalid_i && rready_i;
   assign wr_en     = wvalid_i && !full && !pass_thru && !clr_i;
   assign rd_en     = rready_i && !empty && !clr_i;
   assign depth_cur = depth_f(wptr_q, rptr_q);

   assign wready_o = !full;
   assign rvalid_o = !empty || (Pass && wvalid_i);
   assign rdata_o  = (Pass && empty) ? wdata_i : mem_q[rptr_q[PtrvW-1:0]];
   assign depth_o  = depth_cur[DepthW-1:0];
   assign err_o    = err_q;

   // Next pointers and sticky error; clear overrides any same-cycle transfer.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (clr_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr_en) wptr_d = ptr_inc(wptr_q);
         if (rd_en) rptr_d = ptr_inc(rptr_q);
      end
      err_d = err_q || (wvalid_i && full && !clr_i) || (depth_cur > DepthC);
   end

   // Pointer and error state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         err_q  <= err_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wptr_q[PtrvW-1:0]] <= wdata_i;
   end

`ifdef PRIM_FIFO_WATERMARK_EN
   logic             afull_q, aempty_q;
   logic [CalcW-1:0] depth_nxt;

   assign depth_nxt = depth_f(wptr_d, rptr_d);
   assign afull_o   = afull_q;
   assign aempty_o  = aempty_q;

   // Watermarks registered from next-state depth so they line up with depth_o.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else if (clr_i) begin
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         afull_q  <= (depth_nxt >= CalcW'(wm_hi_i));
         aempty_q <= (depth_nxt <= CalcW'(wm_lo_i));
      end
   end
`endif

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Bench for prim_fifo_sync_wm: directed Depth=3/Pass=0 instance plus a Depth=5/Pass=1
// instance checked every cycle against a queue-based reference model.
module tb_prim_fifo_sync_wm;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // Instance A: Depth=3, Pass=0
   logic        a_clr, a_wvalid, a_wready, a_rvalid, a_rready, a_err;
   logic [15:0] a_wdata, a_rdata;
   logic [1:0]  a_depth;
   // Instance B: Depth=5, Pass=1
   logic        b_clr, b_wvalid, b_wready, b_rvalid, b_rready, b_err;
   logic [15:0] b_wdata, b_rdata;
   logic [2:0]  b_depth;
`ifdef PRIM_FIFO_WATERMARK_EN
   logic [1:0]  a_wm_hi, a_wm_lo;
   logic        a_afull, a_aempty;
   logic [2:0]  b_wm_hi, b_wm_lo;
   logic        b_afull, b_aempty;
`endif

   prim_fifo_sync_wm #(.Width(16), .Depth(3), .Pass(1'b0)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(a_clr), .wvalid_i(a_wvalid), .wready_o(a_wready),
      .wdata_i(a_wdata), .rvalid_o(a_rvalid), .rready_i(a_rready), .rdata_o(a_rdata),
      .depth_o(a_depth), .err_o(a_err)
`ifdef PRIM_FIFO_WATERMARK_EN
      , .wm_hi_i(a_wm_hi), .wm_lo_i(a_wm_lo), .afull_o(a_afull), .aempty_o(a_aempty)
`endif
   );

   prim_fifo_sync_wm #(.Width(16), .Depth(5), .Pass(1'b1)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(b_clr), .wvalid_i(b_wvalid), .wready_o(b_wready),
      .wdata_i(b_wdata), .rvalid_o(b_rvalid), .rready_i(b_rready), .rdata_o(b_rdata),
      .depth_o(b_depth), .err_o(b_err)
`ifdef PRIM_FIFO_WATERMARK_EN
      , .wm_hi_i(b_wm_hi), .wm_lo_i(b_wm_lo), .afull_o(b_afull), .aempty_o(b_aempty)
`endif
   );

   int checks   = 0;
   int failures = 0;

   localparam int BD    = 5;
   localparam int WmHi  = 3;
   localparam int WmLo  = 1;

   // Reference model for B
   logic [15:0] bq [$];
   logic        m_err, m_afull, m_aempty;
   logic [15:0] pat [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic a_step(input logic wv, input logic [15:0] wd, input logic rr);
      @(negedge clk);
      a_wvalid = wv;
      a_wdata  = wd;
      a_rready = rr;
      #1;
   endtask

   // Drive B for one cycle, compare against the model, then advance the model.
   task automatic b_step(input logic wv, input logic [15:0] wd, input logic rr, input logic cl);
      logic        m_empty, m_full;
      logic [15:0] exp_d;
      @(negedge clk);
      b_wvalid = wv;
      b_wdata  = wd;
      b_rready = rr;
      b_clr    = cl;
      #1;
      m_empty = (bq.size() == 0);
      m_full  = (bq.size() == BD);
      chk("b_wready", {31'd0, b_wready}, {31'd0, !m_full});
      chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, (!m_empty || wv)});
      if (!m_empty || wv) begin
         if (m_empty) exp_d = wd;
         else         exp_d = bq[0];
         chk("b_rdata", {16'd0, b_rdata}, {16'd0, exp_d});
      end
      chk("b_depth", {29'd0, b_depth}, bq.size());
      chk("b_err", {31'd0, b_err}, {31'd0, m_err});
`ifdef PRIM_FIFO_WATERMARK_EN
      chk("b_afull", {31'd0, b_afull}, {31'd0, m_afull});
      chk("b_aempty", {31'd0, b_aempty}, {31'd0, m_aempty});
`endif
      if (cl) begin
         bq.delete();
      end else begin
         if (wv && m_full) m_err = 1'b1;
         if (!(m_empty && wv && rr)) begin
            if (rr && !m_empty) void'(bq.pop_front());
            if (wv && !m_full) bq.push_back(wd);
         end
      end
      m_afull  = (bq.size() >= WmHi);
      m_aempty = (bq.size() <= WmLo);
      if (cl) begin
         m_afull  = 1'b0;
         m_aempty = 1'b1;
      end
   endtask

   initial begin
      pat[0] = 16'h00A1;
      pat[1] = 16'h00B2;
      pat[2] = 16'h00C3;
      rst_n = 1'b0;
      a_clr = 1'b0; a_wvalid = 1'b0; a_wdata = '0; a_rready = 1'b0;
      b_clr = 1'b0; b_wvalid = 1'b0; b_wdata = '0; b_rready = 1'b0;
`ifdef PRIM_FIFO_WATERMARK_EN
      a_wm_hi = 2'd2; a_wm_lo = 2'd1;
      b_wm_hi = 3'(WmHi); b_wm_lo = 3'(WmLo);
`endif
      m_err = 1'b0; m_afull = 1'b0; m_aempty = 1'b1;

      // Reset values
      #3;
      chk("rst_a_wready", {31'd0, a_wready}, 32'd1);
      chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
      chk("rst_a_depth", {30'd0, a_depth}, 32'd0);
      chk("rst_a_err", {31'd0, a_err}, 32'd0);
      chk("rst_b_depth", {29'd0, b_depth}, 32'd0);
      chk("rst_b_err", {31'd0, b_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) b_step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("idle_a_wready", {31'd0, a_wready}, 32'd1);
      chk("idle_a_rvalid", {31'd0, a_rvalid}, 32'd0);
      chk("idle_a_depth", {30'd0, a_depth}, 32'd0);

      // A: fill/drain rounds across the pointer wrap
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 3; i++) begin
            a_step(1'b1, pat[i], 1'b0);
            chk("a_fill_depth", {30'd0, a_depth}, i);
            chk("a_fill_rvalid", {31'd0, a_rvalid}, {31'd0, (i != 0)});
         end
         a_step(1'b0, 16'h0, 1'b0);
         chk("a_full_depth", {30'd0, a_depth}, 32'd3);
         chk("a_full_wready", {31'd0, a_wready}, 32'd0);
         for (int i = 0; i < 3; i++) begin
            a_step(1'b0, 16'h0, 1'b1);
            chk("a_rd_rvalid", {31'd0, a_rvalid}, 32'd1);
            chk("a_rd_data", {16'd0, a_rdata}, {16'd0, pat[i]});
            chk("a_rd_depth", {30'd0, a_depth}, 3 - i);
         end
         a_step(1'b0, 16'h0, 1'b0);
         chk("a_empty_rvalid", {31'd0, a_rvalid}, 32'd0);
         chk("a_empty_depth", {30'd0, a_depth}, 32'd0);
         chk("a_empty_wready", {31'd0, a_wready}, 32'd1);
      end

      // A: overrun attempt while full
      for (int i = 0; i < 3; i++) a_step(1'b1, pat[i], 1'b0);
      a_step(1'b1, 16'h00DD, 1'b0);
      chk("a_ovf_err_pre", {31'd0, a_err}, 32'd0);
      a_step(1'b0, 16'h0, 1'b0);
      chk("a_ovf_err", {31'd0, a_err}, 32'd1);
      chk("a_ovf_depth", {30'd0, a_depth}, 32'd3);
      for (int i = 0; i < 3; i++) begin
         a_step(1'b0, 16'h0, 1'b1);
         chk("a_ovf_data", {16'd0, a_rdata}, {16'd0, pat[i]});
      end
      a_step(1'b0, 16'h0, 1'b0);
      chk("a_ovf_err_sticky", {31'd0, a_err}, 32'd1);
      chk("a_ovf_depth_end", {30'd0, a_depth}, 32'd0);

      // B: pass-through when empty
      b_step(1'b1, 16'h0055, 1'b1, 1'b0);
      chk("pass_rdata", {16'd0, b_rdata}, 32'h55);
      chk("pass_rvalid", {31'd0, b_rvalid}, 32'd1);
      b_step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("pass_depth", {29'd0, b_depth}, 32'd0);

      // B: steady simultaneous read+write at depth 2, then clear with write
      b_step(1'b1, 16'h0100, 1'b0, 1'b0);
      b_step(1'b1, 16'h0101, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         b_step(1'b1, 16'(16'h0102 + i), 1'b1, 1'b0);
         chk("rw_depth", {29'd0, b_depth}, 32'd2);
         chk("rw_data", {16'd0, b_rdata}, 32'h100 + i);
      end
      b_step(1'b1, 16'h0200, 1'b0, 1'b1);
      b_step(1'b0, 16'h0, 1'b0, 1'b0);
      chk("clr_depth", {29'd0, b_depth}, 32'd0);
      chk("clr_rvalid", {31'd0, b_rvalid}, 32'd0);
      chk("clr_err", {31'd0, b_err}, 32'd0);

      // B: fill to full and drain (watermarks checked by the model when built)
      for (int i = 0; i < BD; i++) b_step(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
      for (int i = 0; i <= BD; i++) b_step(1'b0, 16'h0, 1'b1, 1'b0);

      // B: randomized traffic
      for (int i = 0; i < 400; i++) begin
         b_step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 31) == 0));
      end

      // Asynchronous reset mid-operation
      b_step(1'b1, 16'h0777, 1'b0, 1'b0);
      b_step(1'b1, 16'h0778, 1'b0, 1'b0);
      @(negedge clk);
      b_wvalid = 1'b0; b_rready = 1'b0; b_clr = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_b_depth", {29'd0, b_depth}, 32'd0);
      chk("mrst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
      chk("mrst_b_err", {31'd0, b_err}, 32'd0);
      chk("mrst_b_wready", {31'd0, b_wready}, 32'd1);
      chk("mrst_a_err", {31'd0, a_err}, 32'd0);
      bq.delete();
      m_err = 1'b0; m_afull = 1'b0; m_aempty = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) b_step(1'b0, 16'h0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
